// File: rtl/midi_cmd_encoder.sv
// MIDI byte stream to synthesizer note-command word.
// Parses channel-voice messages with running status and channel filtering.
module midi_cmd_encoder #(
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [15:0] o_data,
    output logic        o_valid
);

    typedef enum logic [2:0] {
        K_NONE,
        K_OFF,
        K_ON,
        K_CC,
        K_SKIP2,
        K_SKIP1
    } kind_e;

    typedef enum logic {
        PH_D1,
        PH_D2
    } phase_e;

    localparam logic [3:0] CH     = 4'(CHANNEL);
    localparam logic       OMNI_B = (OMNI != 0);

    kind_e       kind_q, kind_d;
    phase_e      phase_q, phase_d;
    logic        match_q, match_d;
    logic [7:0]  d1_q, d1_d;
    logic [15:0] data_q;
    logic        valid_q;

    logic        is_rt, is_sys, is_chan, is_data;
    logic        two_byte;
    logic        complete;
    logic        emit;
    logic [15:0] word;
    logic [6:0]  note, vel;

    function automatic kind_e decode(input logic [3:0] hi);
        kind_e k;
        case (hi)
            4'h8:       k = K_OFF;
            4'h9:       k = K_ON;
            4'hB:       k = K_CC;
            4'hA, 4'hE: k = K_SKIP2;
            4'hC, 4'hD: k = K_SKIP1;
            default:    k = K_NONE;
        endcase
        return k;
    endfunction

    assign is_rt   = i_byte_valid & (i_byte[7:3] == 5'b11111);
    assign is_sys  = i_byte_valid & (i_byte[7:3] == 5'b11110);
    assign is_chan = i_byte_valid & i_byte[7] & (i_byte[7:4] != 4'hF);
    assign is_data = i_byte_valid & ~i_byte[7];

    assign two_byte = (kind_q == K_OFF) | (kind_q == K_ON)
                    | (kind_q == K_CC)  | (kind_q == K_SKIP2);

    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q  <= K_NONE;
            phase_q <= PH_D1;
            match_q <= 1'b0;
            d1_q    <= 8'h00;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            kind_q  <= kind_d;
            phase_q <= phase_d;
            match_q <= match_d;
            d1_q    <= d1_d;
            valid_q <= emit;
            if (emit) begin
                data_q <= word;
            end
        end
    end

    always_comb begin
        kind_d  = kind_q;
        phase_d = phase_q;
        match_d = match_q;
        d1_d    = d1_q;
        unique case (1'b1)
            is_chan: begin
                kind_d  = decode(i_byte[7:4]);
                match_d = OMNI_B | (i_byte[3:0] == CH);
                phase_d = PH_D1;
            end
            is_sys: begin
                kind_d  = K_NONE;
                phase_d = PH_D1;
            end
            is_data: begin
                if (two_byte) begin
                    if (phase_q == PH_D1) begin
                        d1_d    = i_byte;
                        phase_d = PH_D2;
                    end else begin
                        phase_d = PH_D1;
                    end
                end
            end
            is_rt: begin
                phase_d = phase_q;
            end
            default: begin
                phase_d = phase_q;
            end
        endcase
    end

    assign note     = d1_q[6:0];
    assign vel      = i_byte[6:0];
    assign complete = is_data & two_byte & (phase_q == PH_D2) & match_q;

    // Note 127 is reserved: its STOP would alias the STOP_ALL word.
    always_comb begin
        emit = 1'b0;
        word = 16'h0000;
        if (complete) begin
            case (kind_q)
                K_ON: begin
                    if (note != 7'h7F) begin
                        emit = 1'b1;
                        if (vel != 7'h00) begin
                            word = {1'b1, note, 1'b0, vel};
                        end else begin
                            word = {1'b0, note, 8'h00};
                        end
                    end
                end
                K_OFF: begin
                    if (note != 7'h7F) begin
                        emit = 1'b1;
                        word = {1'b0, note, 1'b0, vel};
                    end
                end
                K_CC: begin
                    if (d1_q == 8'd120 || d1_q == 8'd123) begin
                        emit = 1'b1;
                        word = 16'h7F00;
                    end
                end
                default: begin
                    emit = 1'b0;
                end
            endcase
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// Bench for midi_cmd_encoder: two instances (filtered / omni)
// checked against a message-level reference model.
module tb_midi_cmd_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    int          ch_of[2]   = '{0, 3};
    bit          omni_of[2] = '{1'b0, 1'b1};
    int          m_stat[2]  = '{0, 0};
    bit          m_match[2] = '{1'b0, 1'b0};
    bit          m_has[2]   = '{1'b0, 1'b0};
    int          m_d1[2]    = '{0, 0};
    logic [15:0] e_data[2]  = '{16'h0, 16'h0};
    bit          e_valid[2] = '{1'b0, 1'b0};
    int          pc[2]      = '{0, 0};

    always #5 clk = ~clk;

    midi_cmd_encoder #(.CHANNEL(0), .OMNI(0)) u_a (
        .clk(clk), .reset(reset), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_data(a_data), .o_valid(a_valid)
    );

    midi_cmd_encoder #(.CHANNEL(3), .OMNI(1)) u_b (
        .clk(clk), .reset(reset), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_data(b_data), .o_valid(b_valid)
    );

    function automatic void model_step(int u, int b, bit v, bit r);
        int hi;
        e_valid[u] = 1'b0;
        if (r) begin
            m_stat[u] = 0; m_has[u] = 0; m_d1[u] = 0; e_data[u] = 16'h0;
            return;
        end
        if (!v || b >= 248) return;
        if (b >= 240) begin
            m_stat[u] = 0; m_has[u] = 0;
            return;
        end
        if (b >= 128) begin
            m_stat[u]  = b;
            m_match[u] = omni_of[u] || ((b % 16) == ch_of[u]);
            m_has[u]   = 0;
            return;
        end
        hi = m_stat[u] / 16;
        if (m_stat[u] == 0 || hi == 12 || hi == 13) return;
        if (!m_has[u]) begin
            m_d1[u] = b; m_has[u] = 1;
            return;
        end
        m_has[u] = 0;
        if (!m_match[u]) return;
        if (hi == 9 && m_d1[u] != 127) begin
            e_valid[u] = 1'b1;
            e_data[u]  = 16'((b != 0) ? 32768 + m_d1[u] * 256 + b : m_d1[u] * 256);
        end else if (hi == 8 && m_d1[u] != 127) begin
            e_valid[u] = 1'b1;
            e_data[u]  = 16'(m_d1[u] * 256 + b);
        end else if (hi == 11 && (m_d1[u] == 120 || m_d1[u] == 123)) begin
            e_valid[u] = 1'b1;
            e_data[u]  = 16'h7F00;
        end
    endfunction

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad < 30)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                cmp("a_valid", {15'd0, a_valid}, {15'd0, e_valid[0]});
                cmp("a_data", a_data, e_data[0]);
                cmp("b_valid", {15'd0, b_valid}, {15'd0, e_valid[1]});
                cmp("b_data", b_data, e_data[1]);
                if (a_valid === 1'b1) pc[0]++;
                if (b_valid === 1'b1) pc[1]++;
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic v, input logic r);
        @(negedge clk);
        i_byte = b;
        i_byte_valid = v;
        reset = r;
        model_step(0, int'(b), v, r);
        model_step(1, int'(b), v, r);
        chk_en = 1;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b, 1'b1, 1'b0);
    endtask

    task automatic lit(input string name, input bit unit_b,
                       input logic [15:0] d, input logic v);
        @(posedge clk);
        #2;
        cmp({name, "_d"}, unit_b ? b_data : a_data, d);
        cmp({name, "_v"}, {15'd0, unit_b ? b_valid : a_valid}, {15'd0, v});
    endtask

    logic [7:0] hi_tab[10] = '{8'h8, 8'h9, 8'h9, 8'h9, 8'h8, 8'hB, 8'hA, 8'hE, 8'hC, 8'hD};

    initial begin
        int r, p0;
        logic [7:0] b;
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h90, 1'b1, 1'b1);
        send(8'h45); send(8'h64);
        lit("reset_vs_valid", 0, 16'h0000, 1'b0);

        send(8'h90); send(8'h45); send(8'h64);
        lit("note_on", 0, 16'hC564, 1'b1);
        send(8'h40); send(8'h50);
        lit("running_status", 0, 16'hC050, 1'b1);

        p0 = pc[0];
        send(8'h80); send(8'h45); send(8'h10);
        lit("note_off", 0, 16'h4510, 1'b1);
        send(8'h90); send(8'h45); send(8'h00);
        lit("on_vel0", 0, 16'h4500, 1'b1);
        cmp("off_pulses", 16'(pc[0] - p0), 16'd2);

        send(8'hB0); send(8'h7B); send(8'h00);
        lit("stop_all", 0, 16'h7F00, 1'b1);
        send(8'hB0); send(8'h07); send(8'h64);
        lit("cc_volume", 0, 16'h7F00, 1'b0);

        send(8'h90); send(8'hF8); send(8'h45); send(8'hFE); send(8'h64);
        lit("realtime_mid", 0, 16'hC564, 1'b1);
        send(8'hF0); send(8'h45); send(8'h64); send(8'hF7);
        lit("sysex", 0, 16'hC564, 1'b0);
        send(8'h45);
        lit("after_sys", 0, 16'hC564, 1'b0);

        send(8'h80); send(8'h10); send(8'h20);
        lit("pre_filter", 0, 16'h1020, 1'b1);
        send(8'h91); send(8'h45); send(8'h64);
        lit("chan_filter_a", 0, 16'h1020, 1'b0);
        send(8'h91); send(8'h45); send(8'h64);
        lit("chan_omni_b", 1, 16'hC564, 1'b1);
        send(8'hC0); send(8'h05); send(8'h90); send(8'h7F); send(8'h40);
        lit("note127_a", 0, 16'h1020, 1'b0);

        send(8'h90); send(8'h45);
        drive(8'h00, 1'b0, 1'b1);
        send(8'h64);
        lit("reset_mid", 0, 16'h0000, 1'b0);
        send(8'h90); send(8'h3C); send(8'h7F);
        lit("b2b_first", 0, 16'hBC7F, 1'b1);
        send(8'h3E);
        lit("b2b_gap", 0, 16'hBC7F, 1'b0);
        send(8'h7F);
        lit("b2b_second", 0, 16'hBE7F, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(8'($urandom), 1'($urandom), 1'b1);
            end else if (r < 10) begin
                drive(8'($urandom), 1'b0, 1'b0);
            end else if (r < 16) begin
                send(8'hF8 + 8'($urandom_range(0, 7)));
            end else if (r < 20) begin
                send(8'hF0 + 8'($urandom_range(0, 7)));
            end else if (r < 35) begin
                b = hi_tab[$urandom_range(0, 9)];
                send({b[3:0], 4'($urandom_range(0, 4))});
            end else begin
                case ($urandom_range(0, 7))
                    0: send(8'd127);
                    1: send(8'd120);
                    2: send(8'd123);
                    3: send(8'd0);
                    default: send(8'($urandom_range(0, 127)));
                endcase
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/midi_cmd_encoder.md
# midi_cmd_encoder

Converts a raw MIDI byte stream from the UART receiver into the 16-bit note command word consumed by `synthesizer_top` on `i_data`. It parses channel-voice messages, applies running status, filters by channel, and emits START/STOP/STOP_ALL words. It sits between the MIDI UART RX and the synthesizer top, driving the synthesizer's note-command input.

## Interface
- `CHANNEL`, default 0: MIDI channel (0–15) accepted when `OMNI` is 0.
- `OMNI`, default 0: when 1, accept all channels.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `i_byte` in 8: received MIDI byte.
- `i_byte_valid` in 1: one-cycle strobe; `i_byte` is valid in this cycle.
- `o_data` out 16: command word `{on, note[6:0], velocity[7:0]}`. Holds its last value between commands.
- `o_valid` out 1: one-cycle strobe marking a newly updated `o_data`.

## Operation
- **Byte classes.**
  - Status: `i_byte[7]` = 1.
  - Data: `i_byte[7]` = 0.
  - Realtime: 0xF8–0xFF.
  - System common: 0xF0–0xF7.
- **Running-status register.** Holds `{kind, chan_match}`. `kind` is one of NONE, NOTE_OFF (0x8n), NOTE_ON (0x9n), CC (0xBn), SKIP2 (0xAn, 0xEn), SKIP1 (0xCn, 0xDn).
- **Phase register.** Values D1 (expect first data byte) and D2 (expect second). D1 is stored in an 8-bit latch.
- **Channel status byte (0x80–0xEF).**
  - Sets `kind`.
  - Sets `chan_match` = OMNI | (`i_byte[3:0]` == CHANNEL).
  - Sets phase to D1.
  - Discards any partial message.
- **System common (0xF0–0xF7).**
  - Sets `kind` = NONE and phase to D1.
  - Data bytes are then ignored until the next channel status byte. This covers SysEx payloads.
- **Realtime bytes.** Ignored entirely. State, phase and the D1 latch are untouched; they may arrive mid-message.
- **Data byte with `kind` = NONE.** Ignored.
- **SKIP1.** Each data byte is consumed; phase stays at D1.
- **Two-byte kinds.**
  - In D1, latch the byte and go to D2.
  - In D2, the message completes and phase returns to D1. This is running status: further data pairs reuse `kind`.
- **On message completion with `chan_match` = 1:**
  - NOTE_ON, velocity ≠ 0 → `{1, note, 0, vel[6:0]}`.
  - NOTE_ON, velocity = 0 → `{0, note, 0, 0000000}` (STOP).
  - NOTE_OFF → `{0, note, 0, vel[6:0]}`.
  - CC with controller 120 or 123 → STOP_ALL 16'h7F00. Other controllers emit nothing.
  - SKIP2 → nothing.
  - Note 127 is reserved, because STOP of note 127 encodes STOP_ALL. NOTE_ON and NOTE_OFF on note 127 emit nothing.
- **On message completion with `chan_match` = 0:** the message is consumed and nothing is emitted.
- **Output width.** The velocity field is always zero-extended from 7 bits.

## Timing
- **Reset values:** `o_data` = 16'h0000, `o_valid` = 0, `kind` = NONE, phase D1, D1 latch = 0.
- **Latency:** the completing data byte is sampled at edge N. `o_data` and `o_valid` are updated at edge N, so they are visible in cycle N+1. `o_valid` falls at edge N+1 unless another command completes.
- **Throughput:** one byte per cycle. Back-to-back `i_byte_valid` is legal. Bytes are never stalled and there is no backpressure.
- **Idle cycles:** `i_byte_valid` = 0 changes no state; `o_valid` is 0.
- **Reset mid-message:** any partial message and running status are discarded. A following data byte is ignored.
- **Reset with `i_byte_valid` high:** reset wins and the byte is dropped.
- **Output hold:** `o_data` is never cleared except by reset. The downstream block treats a held word as idempotent.

## Test plan
- **Basic note on, running status.** Send 0x90, 0x45, 0x64 → one `o_valid` pulse with `o_data` = 0xC564. Then send 0x40, 0x50 with no status byte → `o_data` = 0xC050.
- **Note off forms.** Send 0x80, 0x45, 0x10 → `o_data` = 0x4510. Then send 0x90, 0x45, 0x00 → `o_data` = 0x4500. Each produces exactly one pulse.
- **Stop all.** Send 0xB0, 0x7B, 0x00 → `o_data` = 0x7F00. Then send 0xB0, 0x07, 0x64 (volume) → no `o_valid`, and `o_data` stays 0x7F00.
- **Interleaved bytes.** Send 0x90, 0xF8, 0x45, 0xFE, 0x64 → `o_data` = 0xC564 one cycle after the last byte. Then send 0xF0, 0x45, 0x64, 0xF7 → no output. A following 0x45 with no status byte → no output.
- **Channel filtering and reserved note.** With CHANNEL = 0, OMNI = 0:
  - 0x91, 0x45, 0x64 → no output.
  - 0xC0, 0x05, then 0x90, 0x7F, 0x40 → no output.
  - Repeat 0x91, 0x45, 0x64 with OMNI = 1 → `o_data` = 0xC564.
- **Reset mid-message.** Send 0x90, 0x45; assert reset for 1 cycle; send 0x64 → no output, and `o_data` = 0x0000. Back-to-back 0x90, 0x3C, 0x7F, 0x3E, 0x7F on consecutive cycles → pulses two cycles apart with 0xBC7F, then 0xBE7F.
